// File: rtl/seg_pkg.sv
// Shared constants and glyph decode for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode driver with frame-synchronous shadow
// update, leading-zero blanking and per-digit decimal points.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1024
) (
  input  logic                    slowClk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [6:0]              outSeg,
  output logic                    outDp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIDX_LAST = DW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pcnt;
  logic [DW-1:0]           didx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;

  logic       tick, boundary, capture;
  logic [3:0] nib_p0;
  logic [6:0] seg_p0;
  logic       lz_blank_p0;

  assign tick     = enable && (pcnt == PCNT_LAST);
  assign boundary = tick && (didx == DIDX_LAST);
  // A disabled display has no frame to tear, so requests are taken at once.
  assign capture  = (pending || load) && (boundary || !enable);

  // Stage p0: select the active digit from the shadow value
  assign nib_p0 = shadow[{didx, 2'b00} +: 4];

  always_comb begin
    lz_blank_p0 = blank_lz && (didx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(didx) && shadow[4*i +: 4] != 4'h0) lz_blank_p0 = 1'b0;
    end
  end

  seg7_decode u_decode (
    .nibble (nib_p0),
    .seg    (seg_p0)
  );

  // Stage p1: registered counters, handshake and pin drivers
  always_ff @(posedge slowClk or posedge reset) begin
    if (reset) begin
      pcnt        <= '0;
      didx        <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      anode       <= '1;
      outSeg      <= SEG_BLANK;
      outDp       <= 1'b1;
    end else begin
      if (enable) begin
        pcnt <= tick ? '0 : pcnt + PW'(1);
        if (tick) didx <= (didx == DIDX_LAST) ? '0 : didx + DW'(1);
      end
      if (capture) shadow <= value;
      pending     <= !capture && (pending || load);
      load_ack    <= capture;
      frame_start <= boundary;
      // Anodes stay dark on the first cycle of a slot while segments settle.
      anode  <= (enable && pcnt != '0) ? ~(NUM_DIGITS'(1) << didx) : '1;
      outSeg <= (enable && !lz_blank_p0) ? seg_p0 : SEG_BLANK;
      outDp  <= !(enable && pcnt != '0 && dp_in[didx]);
    end
  end

endmodule
